// File: rtl/pusher_pkg.sv
// Shared types and constants for the pusher scheduler slice.
package pusher_pkg;

  localparam int unsigned ITEM_W   = 8;
  localparam logic [ITEM_W-1:0] IDLE_ITEM = '0;
  // Widest requester id supported (NUM_REQ up to 8)
  localparam int unsigned ID_MAX_W = 3;

  function automatic int unsigned req_id_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/pusher_arbiter_if.sv
// Requester, pusher and response signals of the pusher arbiter.
// req_lock exists only when PUSHER_ARB_LOCK_EN is defined.
interface pusher_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import pusher_pkg::*;

  localparam int unsigned IW = req_id_w(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ITEM_W-1:0] req_item;
  logic [NUM_REQ-1:0]        req_ready;
`ifdef PUSHER_ARB_LOCK_EN
  logic [NUM_REQ-1:0]        req_lock;
`endif
  logic [ITEM_W-1:0]         push_item;
  logic                      push_valid;
  logic [ITEM_W-1:0]         pusher_out;
  logic                      resp_valid;
  logic [IW-1:0]             resp_id;
  logic [ITEM_W-1:0]         resp_item;
  logic [15:0]               issued_count;

  // Arbiter side
  modport master (
    input  req_valid, req_item, pusher_out,
`ifdef PUSHER_ARB_LOCK_EN
    input  req_lock,
`endif
    output req_ready, push_item, push_valid, resp_valid, resp_id, resp_item, issued_count
  );

  // Requester / pusher environment side
  modport slave (
    output req_valid, req_item, pusher_out,
`ifdef PUSHER_ARB_LOCK_EN
    output req_lock,
`endif
    input  req_ready, push_item, push_valid, resp_valid, resp_id, resp_item, issued_count
  );

endinterface

// File: rtl/pusher_arbiter_rr_select.sv
// Combinational round-robin pick: first set valid bit after ptr, wrapping.
module rr_select
  import pusher_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = req_id_w(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int unsigned c;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    c      = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      c = (32'(ptr) + k) % N;
      if (!any && valid[c]) begin
        any       = 1'b1;
        idx       = IW'(c);
        onehot[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pusher_arbiter.sv
// Round-robin scheduler sharing one pusher stage; tags route responses back.
// Optional macro PUSHER_ARB_LOCK_EN adds req_lock with up to MAX_LOCK repeat grants.
module pusher_arbiter
  import pusher_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned PUSH_LATENCY = 1
`ifdef PUSHER_ARB_LOCK_EN
  ,
  parameter int unsigned MAX_LOCK     = 4
`endif
) (
  input logic               clk,
  input logic               reset,
  pusher_arbiter_if.master  bus
);

  localparam int unsigned IW    = req_id_w(NUM_REQ);
  localparam int unsigned CMP_W = ID_MAX_W + 1;

  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      sel_idx;
  logic [IW-1:0]      g;
  logic [NUM_REQ-1:0] sel_onehot;
  logic [NUM_REQ-1:0] grant;
  logic               sel_any;
  logic               xfer;
  logic               lock_hit;
  logic [ITEM_W-1:0]  item_sel;
  logic [ITEM_W-1:0]  push_item_q;
  logic               push_valid_q;
  logic [15:0]        issued_q;
  tag_t [PUSH_LATENCY:0] pipe;

  rr_select #(.N(NUM_REQ)) u_sel (
    .valid  (bus.req_valid),
    .ptr    (rr_ptr),
    .onehot (sel_onehot),
    .idx    (sel_idx),
    .any    (sel_any)
  );

`ifdef PUSHER_ARB_LOCK_EN
  localparam int unsigned CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] lock_cnt;

  // Last winner keeps the grant while locked, until it has MAX_LOCK in a row
  assign lock_hit = bus.req_lock[rr_ptr] & bus.req_valid[rr_ptr] & (lock_cnt < CW'(MAX_LOCK));

  always_ff @(posedge clk) begin
    if (reset)         lock_cnt <= '0;
    else if (!xfer)    lock_cnt <= '0;
    else if (lock_hit) lock_cnt <= lock_cnt + CW'(1);
    else               lock_cnt <= CW'(1);
  end
`else
  assign lock_hit = 1'b0;
`endif

  always_comb begin
    grant = sel_onehot;
    g     = sel_idx;
    if (lock_hit) begin
      grant         = '0;
      grant[rr_ptr] = 1'b1;
      g             = rr_ptr;
    end
    if (reset || !(sel_any || lock_hit)) grant = '0;
  end

  assign xfer = |grant;

  always_comb begin
    item_sel = IDLE_ITEM;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) item_sel = bus.req_item[i*ITEM_W +: ITEM_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      push_item_q  <= IDLE_ITEM;
      push_valid_q <= 1'b0;
      rr_ptr       <= IW'(NUM_REQ - 1);
      issued_q     <= '0;
      pipe         <= '0;
    end else begin
      push_item_q  <= item_sel;
      push_valid_q <= xfer;
      if (xfer) rr_ptr <= g;
      if (xfer && (issued_q != 16'hFFFF)) issued_q <= issued_q + 16'd1;
      pipe[0] <= '{valid: xfer, id: ID_MAX_W'(g)};
      for (int unsigned k = 1; k <= PUSH_LATENCY; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign bus.req_ready    = grant;
  assign bus.push_item    = push_item_q;
  assign bus.push_valid   = push_valid_q;
  assign bus.issued_count = issued_q;
  // An out-of-range id can never be routed, so it never raises resp_valid
  assign bus.resp_valid   = pipe[PUSH_LATENCY].valid &
                            (CMP_W'(pipe[PUSH_LATENCY].id) < CMP_W'(NUM_REQ));
  assign bus.resp_id      = IW'(pipe[PUSH_LATENCY].id);
  assign bus.resp_item    = bus.pusher_out;

endmodule

// File: doc/pusher_arbiter.md
Name: pusher_arbiter

Overview:
Round-robin scheduler that shares one pusher datapath stage between NUM_REQ requesters over a valid/ready handshake. Each cycle it selects at most one requester and registers that requester's 8-bit item onto the pusher input. A tag shift register of PUSH_LATENCY stages returns each pusher output to the requester that issued the item. Sits between the requester front-ends and the pusher instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ITEM_W, 8, item width; matches the pusher item width
PUSH_LATENCY, 1, pusher input-to-output latency in cycles (>=1)
IDLE_ITEM, 0, value driven on push_item when no requester is granted
MAX_LOCK, 4, maximum consecutive grants to one requester under lock (feature only)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester item valid
req_item  input  NUM_REQ*ITEM_W  per-requester item; requester i occupies bits [i*ITEM_W +: ITEM_W]
req_ready  output  NUM_REQ  one-hot grant, combinational, this cycle
push_item  output  ITEM_W  registered item to the pusher item_in
push_valid  output  1  registered; push_item carries a real item
pusher_out  input  ITEM_W  pusher item_out
resp_valid  output  1  pusher_out is a real response this cycle
resp_id  output  $clog2(NUM_REQ)  owner of the current response
resp_item  output  ITEM_W  equals pusher_out (combinational pass-through)
issued_count  output  16  total items issued; saturates at 0xFFFF

Behaviour:
- Reset (synchronous, while reset=1 at posedge):
  - push_item=IDLE_ITEM, push_valid=0, tag pipe cleared (resp_valid=0, resp_id=0), issued_count=0.
  - rr_ptr=NUM_REQ-1, so requester 0 has top priority after reset.
  - req_ready=0 while reset is high.
- Arbitration (combinational):
  - Search req_valid starting at index rr_ptr+1 mod NUM_REQ; the first set bit is index g.
  - req_ready = one-hot(g), or all zeros if no req_valid is set.
  - A transfer occurs when req_valid[g] & req_ready[g]. req_ready never depends on the requester asserting anything other than req_valid.
- Issue (registered, one cycle):
  - On a transfer: push_item<=req_item[g], push_valid<=1, rr_ptr<=g, issued_count<=issued_count+1 (holds at 0xFFFF).
  - Without a transfer: push_item<=IDLE_ITEM, push_valid<=0, rr_ptr unchanged.
- Tag pipe:
  - Stage 0 captures {transfer, g} at the same edge as push_item.
  - Stage k+1 captures stage k each cycle.
  - resp_valid/resp_id are driven from stage PUSH_LATENCY. A response therefore appears exactly PUSH_LATENCY cycles after push_valid, and PUSH_LATENCY+1 cycles after the handshake.
- The pusher advances every cycle and has no backpressure. Issue rate is up to 1 item/cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0,...; no requester waits more than NUM_REQ-1 cycles.
- A requester that drops req_valid before being granted is simply skipped; no state is retained for it.
- Reset mid-operation: in-flight tags are discarded, so no resp_valid is produced for items issued before reset. The pusher's own contents are not this block's concern.

Optional Feature:
Macro PUSHER_ARB_LOCK_EN. When defined, adds input req_lock [NUM_REQ] and an internal lock counter:
- If the last-granted requester g holds req_lock[g]=1 and req_valid[g]=1, it is granted again, overriding the rotation.
- This repeats for up to MAX_LOCK consecutive grants in total. On the next cycle rotation is forced past g, and the counter resets.
- The counter also resets on any grant to a different requester, or whenever req_lock[g]=0.

When the macro is undefined: no req_lock port, pure round-robin.

Decomposition:
- Package pusher_pkg: ITEM_W, IDLE_ITEM, the req_id width function, and the tag struct {valid, id}.
- Sub-module rr_select: pure combinational round-robin priority pick (inputs valid vector and ptr; outputs one-hot and index). It is reused by later schedulers.
- The tag pipe stays inline.

Test Plan:
1. Reset held 3 cycles with req_valid=4'b1111 -> req_ready=0, push_valid=0, push_item=0, issued_count=0. After release, the first grant goes to requester 0.
2. All valid, req_item[i]=8'h10+i, 8 cycles -> push_item sequence 10,11,12,13,10,11,12,13. With a pass-through pusher model, resp_id follows 0,1,2,3,... PUSH_LATENCY cycles after each push_valid.
3. Only requester 2 valid, item 8'hA5, 5 cycles -> grant to 2 every cycle, push_valid=1 throughout, issued_count=5.
4. req_valid=0 for 3 cycles between bursts -> push_item=IDLE_ITEM, push_valid=0, and 3 bubble cycles with resp_valid=0 at the output.
5. Reset asserted one cycle after an issue with PUSH_LATENCY=3 -> no resp_valid is ever produced for that item. issued_count=0 and rotation restarts at requester 0.
6. (PUSHER_ARB_LOCK_EN) Requesters 1 and 3 valid, req_lock[1]=1, MAX_LOCK=4 -> grants 1,1,1,1,3,1,1,1,1,3.
